// File: rtl/sam_tape_player.sv
// sam_tape_player: replays a hyperload byte stream from the tape FIFO as a
// ROM-loader tape waveform (pilot, sync, data, pause) on a single EAR bit.
// Ports: clk50m/reset (async, active-high), enable (play/freeze),
//   fifo_empty/fifo_data/fifo_rd (FIFO read side, q valid the cycle after rd),
//   ear_out (tape bit), busy, block_done (end-of-pause pulse), underrun (sticky).
module sam_tape_player #(
    parameter int PILOT_LEN  = 30971,
    parameter int SYNC1_LEN  = 9529,
    parameter int SYNC2_LEN  = 10500,
    parameter int ZERO_LEN   = 12214,
    parameter int ONE_LEN    = 24429,
    parameter int PILOT_HDR  = 8063,
    parameter int PILOT_DATA = 3223,
    parameter int PAUSE_LEN  = 50000000
) (
    input  logic       clk50m,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       ear_out,
    output logic       busy,
    output logic       block_done,
    output logic       underrun
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LEN_LO = 4'd1;
    localparam logic [3:0] S_LEN_HI = 4'd2;
    localparam logic [3:0] S_FLAG   = 4'd3;
    localparam logic [3:0] S_PILOT  = 4'd4;
    localparam logic [3:0] S_SYNC1  = 4'd5;
    localparam logic [3:0] S_SYNC2  = 4'd6;
    localparam logic [3:0] S_DATA   = 4'd7;
    localparam logic [3:0] S_PAUSE  = 4'd8;

    // Counters reload with length-1 and expire at zero, giving an exact
    // period of LEN cycles with the next load on the expiry cycle.
    localparam logic [25:0] C_PILOT = 26'(PILOT_LEN - 1);
    localparam logic [25:0] C_SYNC1 = 26'(SYNC1_LEN - 1);
    localparam logic [25:0] C_SYNC2 = 26'(SYNC2_LEN - 1);
    localparam logic [25:0] C_ZERO  = 26'(ZERO_LEN - 1);
    localparam logic [25:0] C_ONE   = 26'(ONE_LEN - 1);
    localparam logic [25:0] C_PAUSE = 26'(PAUSE_LEN - 1);
    localparam logic [12:0] N_HDR   = 13'(PILOT_HDR);
    localparam logic [12:0] N_DATA  = 13'(PILOT_DATA);

    logic [3:0]  state;
    logic [25:0] cnt;
    logic [12:0] pcnt;
    logic [15:0] rem;
    logic [7:0]  len_lo;
    logic [7:0]  sh;
    logic [7:0]  nbuf;
    logic        nvalid;
    logic        stall;
    logic [2:0]  bit_idx;
    logic        half;
    logic        rd_q;
    logic        cap;
    logic        ear;
    logic        want;
    logic        issue;
    logic        expired;
    logic        boundary;

    function automatic logic [25:0] bit_len(input logic b);
        return b ? C_ONE : C_ZERO;
    endfunction

    assign expired  = (cnt == 26'd0);
    assign boundary = !stall && expired && half && (bit_idx == 3'd0);

    // Only one read may be outstanding: rd_q is the strobe cycle and cap
    // the cycle on which fifo_data is valid.
    assign want = (state == S_IDLE) || (state == S_LEN_HI) ||
                  (state == S_FLAG) ||
                  ((state == S_DATA) && (bit_idx == 3'd0) &&
                   (rem != 16'd0) && !nvalid);
    assign issue = enable && !fifo_empty && !rd_q && !cap && want;

    // A strobe left pending by a freeze is held back until enable returns.
    assign fifo_rd = rd_q && enable;
    assign ear_out = ear;
    assign busy    = (state != S_IDLE) || block_done;

    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pcnt       <= '0;
            rem        <= '0;
            len_lo     <= '0;
            sh         <= '0;
            nbuf       <= '0;
            nvalid     <= 1'b0;
            stall      <= 1'b0;
            bit_idx    <= '0;
            half       <= 1'b0;
            rd_q       <= 1'b0;
            cap        <= 1'b0;
            ear        <= 1'b0;
            underrun   <= 1'b0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            if (enable) begin
                rd_q <= issue;
                cap  <= rd_q;
                unique case (state)
                    S_IDLE: begin
                        if (issue) state <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        if (cap) begin
                            len_lo <= fifo_data;
                            state  <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (cap) begin
                            if ({fifo_data, len_lo} == 16'd0) begin
                                ear   <= 1'b0;
                                cnt   <= C_PAUSE;
                                state <= S_PAUSE;
                            end else begin
                                rem   <= {fifo_data, len_lo};
                                state <= S_FLAG;
                            end
                        end
                    end
                    S_FLAG: begin
                        if (cap) begin
                            sh    <= fifo_data;
                            rem   <= rem - 16'd1;
                            pcnt  <= fifo_data[7] ? N_DATA : N_HDR;
                            cnt   <= C_PILOT;
                            state <= S_PILOT;
                        end
                    end
                    S_PILOT: begin
                        if (!expired) begin
                            cnt <= cnt - 26'd1;
                        end else begin
                            ear <= ~ear;
                            if (pcnt <= 13'd1) begin
                                cnt   <= C_SYNC1;
                                state <= S_SYNC1;
                            end else begin
                                pcnt <= pcnt - 13'd1;
                                cnt  <= C_PILOT;
                            end
                        end
                    end
                    S_SYNC1: begin
                        if (!expired) begin
                            cnt <= cnt - 26'd1;
                        end else begin
                            ear   <= ~ear;
                            cnt   <= C_SYNC2;
                            state <= S_SYNC2;
                        end
                    end
                    S_SYNC2: begin
                        if (!expired) begin
                            cnt <= cnt - 26'd1;
                        end else begin
                            ear     <= ~ear;
                            bit_idx <= 3'd7;
                            half    <= 1'b0;
                            cnt     <= bit_len(sh[7]);
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (cap) rem <= rem - 16'd1;
                        // A byte landing at the boundary or during a stall is
                        // played directly; otherwise it waits in nbuf.
                        if (cap && !(stall || boundary)) begin
                            nbuf   <= fifo_data;
                            nvalid <= 1'b1;
                        end
                        if (stall) begin
                            if (cap) begin
                                stall   <= 1'b0;
                                sh      <= fifo_data;
                                bit_idx <= 3'd7;
                                half    <= 1'b0;
                                cnt     <= bit_len(fifo_data[7]);
                            end
                        end else if (!expired) begin
                            cnt <= cnt - 26'd1;
                        end else if (!half) begin
                            ear  <= ~ear;
                            half <= 1'b1;
                            cnt  <= bit_len(sh[7]);
                        end else if (bit_idx != 3'd0) begin
                            ear     <= ~ear;
                            half    <= 1'b0;
                            bit_idx <= bit_idx - 3'd1;
                            sh      <= {sh[6:0], 1'b0};
                            cnt     <= bit_len(sh[6]);
                        end else if (nvalid) begin
                            ear     <= ~ear;
                            half    <= 1'b0;
                            bit_idx <= 3'd7;
                            sh      <= nbuf;
                            nvalid  <= 1'b0;
                            cnt     <= bit_len(nbuf[7]);
                        end else if (cap) begin
                            ear     <= ~ear;
                            half    <= 1'b0;
                            bit_idx <= 3'd7;
                            sh      <= fifo_data;
                            cnt     <= bit_len(fifo_data[7]);
                        end else if (rem == 16'd0) begin
                            ear   <= 1'b0;
                            cnt   <= C_PAUSE;
                            state <= S_PAUSE;
                        end else begin
                            // Last edge of the byte is still emitted; ear then
                            // holds until the late byte is captured.
                            ear      <= ~ear;
                            stall    <= 1'b1;
                            underrun <= 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (!expired) begin
                            cnt <= cnt - 26'd1;
                        end else begin
                            block_done <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sam_tape_player.md
# sam_tape_player

Consumes the hyperload byte stream that the control module pushes into the 512-byte tape FIFO, and regenerates a standard ROM-loader tape waveform on a single EAR bit. The top level XORs that bit into the SAM EAR input. Sits directly downstream of the FIFO: it owns the FIFO read strobe (`hyperload_fifo_rd`) and consumes `hyperload_fifo_data`/`hyperload_fifo_empty`. Stream format is a sequence of blocks, each a 16-bit little-endian length followed by that many payload bytes (flag, data, checksum), played as pilot/sync/data/pause.

## Interface
Parameters (all durations in clk50m cycles):
- PILOT_LEN, 30971 — one pilot half-pulse (2168 T @3.5 MHz)
- SYNC1_LEN, 9529 — first sync half-pulse
- SYNC2_LEN, 10500 — second sync half-pulse
- ZERO_LEN, 12214 — half-pulse for a 0 bit
- ONE_LEN, 24429 — half-pulse for a 1 bit
- PILOT_HDR, 8063 — pilot half-pulses when flag byte < 0x80
- PILOT_DATA, 3223 — pilot half-pulses when flag byte ≥ 0x80
- PAUSE_LEN, 50000000 — post-block silence (1 s)

Ports:
- clk50m in 1 — single clock
- reset in 1 — asynchronous, active-high
- enable in 1 — play; low freezes all counters and outputs
- fifo_empty in 1 — FIFO empty
- fifo_data in 8 — FIFO q, valid on the cycle after fifo_rd
- fifo_rd out 1 — one-cycle read strobe
- ear_out out 1 — tape signal
- busy out 1 — high in any state other than IDLE
- block_done out 1 — one-cycle pulse at the end of PAUSE
- underrun out 1 — sticky; set when a payload byte is needed and the FIFO is empty

## Operation
- States: IDLE, LEN_LO, LEN_HI, FLAG, PILOT, SYNC1, SYNC2, DATA, PAUSE. Every fetch state waits for a byte before it can leave.
- Fetch handshake:
  - Assert fifo_rd for one cycle only when `!fifo_empty && enable`.
  - Capture fifo_data exactly one cycle later.
  - Never issue a second fifo_rd before the previous capture has happened.
- IDLE: when the FIFO is non-empty, read and go to LEN_LO. Then read the high byte in LEN_HI to form len[15:0].
  - len == 0 → go straight to PAUSE (no pilot).
- FLAG: read the first payload byte into the shift register and set len−1 as remaining. Pilot count is PILOT_HDR if flag[7]==0, else PILOT_DATA.
- Half-pulses: each state loads a down-counter with its length. ear_out toggles when the counter expires and the next half-pulse loads on the same cycle, so there are no gap cycles.
- PILOT: emit N half-pulses of PILOT_LEN, then SYNC1 (one half-pulse), then SYNC2 (one half-pulse), then DATA.
- DATA: bytes are sent MSB first. Each bit is 2 half-pulses of ZERO_LEN or ONE_LEN.
- Prefetch: while the current byte's bit 0 is playing, fetch the next byte if remaining > 0.
- Byte boundary with remaining > 0 and no prefetched byte available:
  - set underrun;
  - hold ear_out and stall until a byte arrives;
  - then continue with that byte's first bit.
- Last bit of the last byte done → PAUSE. On entry ear_out is forced to 0 and a PAUSE_LEN countdown starts. At expiry: block_done pulse, then IDLE.
- enable low: counter, state and ear_out hold and fifo_rd stays 0. An expiry that coincides with enable=0 is deferred until enable returns.
- Reset (any time): state IDLE, ear_out 0, fifo_rd 0, busy 0, block_done 0, underrun 0, counters 0. FIFO contents are not affected; the FIFO has its own reset.

## Timing
- The first fifo_rd comes 1 cycle after fifo_empty deasserts in IDLE with enable high.
- First pilot edge: ear_out first toggles PILOT_LEN cycles after the PILOT load cycle. The PILOT load cycle is the cycle after the FLAG byte capture.
- Half-pulse period is exactly the parameter value in cycles, with ±0 jitter except during a stall.
- Pulse counts:
  - pilot: exactly N toggles;
  - sync: 2 toggles total;
  - each data byte: 16 toggles.
- busy rises on the cycle of the first fifo_rd. It falls on the cycle after the block_done pulse.
- Width rules:
  - counter is 26 bits;
  - pilot counter 13 bits;
  - remaining-length counter 16 bits, decremented at each byte capture with no wrap. len=0xFFFF must play 65535 bytes.

## Test plan
(Simulate with PILOT_LEN=10, SYNC1=3, SYNC2=4, ZERO=5, ONE=9, PILOT_HDR=6, PILOT_DATA=4, PAUSE=20.)
- Block 02 00 00 A5 preloaded, enable=1 → 6 pilot toggles at 10-cycle spacing, sync 3/4, then 16 toggles for 0x00 (spacing 5) and 16 for 0xA5 (pattern 9,9,5,5,9,9,5,5,5,5,9,9,5,5,9,9). ear_out then 0 for 20 cycles, block_done one pulse, busy low.
- Flag 0xFF, length 1 → 4 pilot half-pulses, total 4+2+16 toggles.
- Length 00 00 → no toggles, block_done after 20 pause cycles, exactly 2 fifo_rd.
- FIFO runs empty after the flag byte of a length-3 block → underrun=1, ear_out frozen. Writing the byte resumes with correct bit timing and no extra toggle.
- enable low for 7 cycles mid-pilot → every later edge is shifted by exactly 7 cycles and no fifo_rd occurs while low.
- reset asserted in DATA → next cycle ear_out=0, busy=0, underrun=0. The next FIFO byte is treated as LEN_LO.
